// File: rtl/register_ram_pkg.sv
// Shared constants and types for the register RAM sequencer/arbiter.
package register_ram_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  // Sequencer states: fill the RAM, then arbitrate.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Requester ids, also the bit positions in the req/gnt vectors.
  localparam int unsigned REQ_A = 0;
  localparam int unsigned REQ_B = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a combinational one-hot grant.
module rr_arbiter2
  import register_ram_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  // High when B received the most recent grant; reset value prefers A.
  logic r_last_b;

  // Grant the sole requester, or the one not granted last under contention.
  always_comb begin
    gnt = '0;
    if (enable) begin
      case (req)
        2'b01:   gnt[REQ_A] = 1'b1;
        2'b10:   gnt[REQ_B] = 1'b1;
        2'b11: begin
          if (r_last_b) gnt[REQ_A] = 1'b1;
          else          gnt[REQ_B] = 1'b1;
        end
        default: gnt = '0;
      endcase
    end
  end

  // Pointer moves only when a grant is actually issued.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)         r_last_b <= 1'b1;
    else if (gnt[REQ_B])  r_last_b <= 1'b1;
    else if (gnt[REQ_A])  r_last_b <= 1'b0;
  end

endmodule

// File: rtl/register_ram_arbiter.sv
// Fill sequencer and two-port round-robin front end for the register RAM.
module register_ram_arbiter
  import register_ram_pkg::*;
#(
  parameter int unsigned       ADDR_W     = ADDR_W_DEF,
  parameter int unsigned       DATA_W     = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VALUE = '1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              init_start,
  output logic              init_busy,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [DATA_W-1:0] r_hold_data;
  logic              r_a_rvalid;
  logic              r_b_rvalid;
  logic [1:0]        w_gnt;
  logic              w_arb_en;

  // No grant in INIT, nor in the RUN cycle that requests a refill.
  assign w_arb_en = (r_state == ST_RUN) && !init_start;

  rr_arbiter2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     ({b_req, a_req}),
    .enable  (w_arb_en),
    .gnt     (w_gnt)
  );

  assign a_gnt     = w_gnt[REQ_A];
  assign b_gnt     = w_gnt[REQ_B];
  assign init_busy = (r_state == ST_INIT);
  assign a_rvalid  = r_a_rvalid;
  assign b_rvalid  = r_b_rvalid;
  assign a_rdata   = r_a_rvalid ? ram_data_out : '0;
  assign b_rdata   = r_b_rvalid ? ram_data_out : '0;

  // Sequencer: count through every address in INIT, wrap to 0 on entering RUN.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (init_start) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Remember the last granted address/data so the RAM bus is quiet when idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_addr <= '0;
      r_hold_data <= '0;
    end else if (w_gnt[REQ_A]) begin
      r_hold_addr <= a_addr;
      r_hold_data <= a_wdata;
    end else if (w_gnt[REQ_B]) begin
      r_hold_addr <= b_addr;
      r_hold_data <= b_wdata;
    end
  end

  // Read return flags: one cycle after an accepted read on that port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_a_rvalid <= w_gnt[REQ_A] & ~a_we;
      r_b_rvalid <= w_gnt[REQ_B] & ~b_we;
    end
  end

  // RAM port mux: fill pattern in INIT, granted requester in RUN, else hold.
  always_comb begin
    ram_write_en = 1'b0;
    ram_address  = r_hold_addr;
    ram_data_in  = r_hold_data;
    if (r_state == ST_INIT) begin
      ram_write_en = 1'b1;
      ram_address  = r_cnt;
      ram_data_in  = INIT_VALUE;
    end else if (w_gnt[REQ_A]) begin
      ram_write_en = a_we;
      ram_address  = a_addr;
      ram_data_in  = a_wdata;
    end else if (w_gnt[REQ_B]) begin
      ram_write_en = b_we;
      ram_address  = b_addr;
      ram_data_in  = b_wdata;
    end
  end

endmodule

// File: tb/tb_register_ram_arbiter.sv
// Directed bench for register_ram_arbiter with a behavioural 256x8 RAM.
module tb_register_ram_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       init_start;
  logic       init_busy;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_write_en;
  logic [7:0] ram_address, ram_data_in, ram_data_out;
  logic [7:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  register_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .INIT_VALUE(8'hFF)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .init_start   (init_start),
    .init_busy    (init_busy),
    .a_req        (a_req),
    .a_we         (a_we),
    .a_addr       (a_addr),
    .a_wdata      (a_wdata),
    .a_gnt        (a_gnt),
    .a_rvalid     (a_rvalid),
    .a_rdata      (a_rdata),
    .b_req        (b_req),
    .b_we         (b_we),
    .b_addr       (b_addr),
    .b_wdata      (b_wdata),
    .b_gnt        (b_gnt),
    .b_rvalid     (b_rvalid),
    .b_rdata      (b_rdata),
    .ram_write_en (ram_write_en),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  // Synchronous-read RAM, read-before-write.
  always @(posedge clock) begin
    if (ram_write_en) mem[ram_address] <= ram_data_in;
    ram_data_out <= mem[ram_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_fill();
    for (int k = 0; k < 256; k++) begin
      #1;
      check("fill_busy", init_busy, 1);
      check("fill_we", ram_write_en, 1);
      check("fill_addr", ram_address, k);
      check("fill_data", ram_data_in, 8'hFF);
      check("fill_gnt", {a_gnt, b_gnt}, 0);
      cyc();
    end
    #1;
    check("fill_done_busy", init_busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; init_start = 1'b0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    #2;
    check("rst_busy", init_busy, 1);
    check("rst_gnt", {a_gnt, b_gnt}, 0);
    check("rst_rvalid", {a_rvalid, b_rvalid}, 0);
    check("rst_we", ram_write_en, 1);
    check("rst_addr", ram_address, 0);

    // Release reset, both ports reading through the fill.
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    a_req = 1; a_addr = 8'h01;
    b_req = 1; b_addr = 8'h02;
    check_fill();

    // Continuous contention: A, B, A, B, A, B; each rvalid one cycle later.
    for (int i = 0; i < 6; i++) begin
      if (i > 0) #1;
      check("rr_a_gnt", a_gnt, (i % 2 == 0));
      check("rr_b_gnt", b_gnt, (i % 2 == 1));
      check("rr_addr", ram_address, (i % 2 == 0) ? 8'h01 : 8'h02);
      check("rr_a_rvalid", a_rvalid, (i > 0) && (i % 2 == 1));
      check("rr_b_rvalid", b_rvalid, (i > 0) && (i % 2 == 0));
      if (i > 0) check("rr_rdata", (i % 2 == 1) ? a_rdata : b_rdata, 8'hFF);
      cyc();
    end
    a_req = 0; b_req = 0;
    #1;
    check("rr_last_b_rvalid", b_rvalid, 1);
    check("rr_last_a_rvalid", a_rvalid, 0);
    check("idle_we", ram_write_en, 0);
    check("idle_addr_hold", ram_address, 8'h02);
    cyc();

    // A writes 5A to 10, then reads it back.
    a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 8'h5A;
    #1;
    check("aw_gnt", a_gnt, 1);
    check("aw_we", ram_write_en, 1);
    check("aw_data", ram_data_in, 8'h5A);
    cyc();
    a_we = 0;
    #1;
    check("aw_no_rvalid", a_rvalid, 0);
    check("ar_gnt", a_gnt, 1);
    cyc();
    a_req = 0;
    #1;
    check("ar_rvalid", a_rvalid, 1);
    check("ar_rdata", a_rdata, 8'h5A);
    check("ar_b_rvalid", b_rvalid, 0);
    cyc();

    // B writes 33 to 20, A reads 20 on the next cycle and sees new data.
    b_req = 1; b_we = 1; b_addr = 8'h20; b_wdata = 8'h33;
    #1;
    check("hz_b_gnt", b_gnt, 1);
    cyc();
    b_req = 0; b_we = 0;
    a_req = 1; a_addr = 8'h20;
    #1;
    check("hz_b_no_rvalid", b_rvalid, 0);
    check("hz_a_gnt", a_gnt, 1);
    cyc();
    a_addr = 8'h10;
    #1;
    check("hz_rvalid", a_rvalid, 1);
    check("hz_rdata", a_rdata, 8'h33);
    check("a_rd10_gnt", a_gnt, 1);
    cyc();

    // Refill request while A's read data is owed and B holds a read.
    a_req = 0;
    init_start = 1;
    b_req = 1; b_addr = 8'h10;
    #1;
    check("ist_owed_rvalid", a_rvalid, 1);
    check("ist_owed_rdata", a_rdata, 8'h5A);
    check("ist_b_gnt", b_gnt, 0);
    cyc();
    init_start = 0;
    check_fill();
    check("refill_b_gnt", b_gnt, 1);
    cyc();
    b_req = 0;
    #1;
    check("refill_rvalid", b_rvalid, 1);
    check("refill_rdata", b_rdata, 8'hFF);
    cyc();

    // Reset during cycle 100 of a fill.
    init_start = 1;
    cyc();
    init_start = 0;
    for (int k = 0; k < 100; k++) cyc();
    #1;
    check("mid_addr", ram_address, 100);
    #1;
    reset_n = 0;
    #1;
    check("mr_busy", init_busy, 1);
    check("mr_addr", ram_address, 0);
    check("mr_we", ram_write_en, 1);
    check("mr_gnt", {a_gnt, b_gnt}, 0);
    check("mr_rvalid", {a_rvalid, b_rvalid}, 0);
    @(negedge clock);
    reset_n = 1;
    check_fill();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/register_ram_arbiter.md
# register_ram_arbiter

Sequencer and two-port arbiter in front of the 256 x 8 register RAM (synchronous read, one-cycle latency, write-enable port). After every reset it fills all 256 locations with a known value. It then shares the single RAM port between requester A (CPU microsequencer register path) and requester B (front-panel / DMA access), using round-robin arbitration with a valid/grant handshake and a tagged read-return.

## Interface
Parameters:
- ADDR_W, 8, RAM address width (depth = 2**ADDR_W)
- DATA_W, 8, RAM data width
- INIT_VALUE, 8'hFF, value written to every location during init

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- init_start  in  1  pulse in RUN to re-run the fill sequence
- init_busy  out  1  high while in INIT
- a_req  in  1  requester A wants an access; a_we/a_addr/a_wdata stable while high
- a_we  in  1  1 = write, 0 = read
- a_addr  in  ADDR_W  address
- a_wdata  in  DATA_W  write data
- a_gnt  out  1  access accepted at this clock edge
- a_rvalid  out  1  a_rdata valid (one cycle after accepted read)
- a_rdata  out  DATA_W  read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A for requester B
- ram_write_en  out  1  to RAM write_en
- ram_address  out  ADDR_W  to RAM address
- ram_data_in  out  DATA_W  to RAM data_in
- ram_data_out  in  DATA_W  from RAM data_out

## Operation
- States: INIT, RUN. Reset forces INIT, init counter = 0, rr pointer = "A preferred", a_rvalid = b_rvalid = 0.
- INIT: ram_write_en = 1, ram_address = counter, ram_data_in = INIT_VALUE. Counter increments each edge. At the edge where counter = 2**ADDR_W-1, go to RUN with counter = 0. a_gnt = b_gnt = 0, init_busy = 1.
- While reset_n is low, address 0 is driven with INIT_VALUE. This is harmless and deterministic.
- RUN: gnt is combinational from req and pointer.
  - Only one requester active: that requester is granted.
  - Both active: the requester not granted last is granted.
  - Pointer updates only on a grant.
  - At most one gnt per cycle. The granted port's we/addr/wdata drive the RAM.
  - With no grant: ram_write_en = 0 and address/data hold the last granted values.
- Handshake: a transfer occurs at an edge with req & gnt. The requester must keep fields stable until then. It may deassert req or present a new request in the next cycle.
- Read return: rvalid of the granted port is registered high for exactly the one cycle after an accepted read. rdata = ram_data_out, passed combinationally and qualified by rvalid. Writes produce no rvalid.
- A read of an address written in the same edge returns the old data (RAM read-before-write). A read one cycle later returns the new data.
- init_start is honoured only in RUN. The next edge enters INIT at counter 0 and no grant is issued that cycle. An rvalid owed from the previous edge is still delivered.

## Timing
- Reset values: init_busy = 1, a_gnt = b_gnt = 0, a_rvalid = b_rvalid = 0, ram_write_en = 1, ram_address = 0.
- Init: reset_n rises before edge 0. Edges 0..255 write addresses 0..255. The first grant can be accepted at edge 256, and init_busy is low after edge 255.
- Read latency: accept at edge N; rvalid/rdata are valid between edges N and N+1.
- Throughput: one access per cycle, back-to-back. Under continuous contention, A and B alternate exactly.
- Reset asserted mid-INIT or mid-transfer: immediate return to INIT at 0. Pending rvalid is cleared and the fill restarts in full.

## Structure
- Shared package/include register_ram_pkg: ADDR_W, DATA_W defaults, state encoding (ST_INIT, ST_RUN), requester id constants (REQ_A = 0, REQ_B = 1).
- One sub-module, rr_arbiter2: 2-way round-robin with a pointer register, inputs req[1:0] and enable, output one-hot gnt[1:0]. The top contains the FSM, init counter, muxes and rvalid registers.

## Test plan
- Reset release → init_busy high for exactly 256 cycles. ram_write_en high with addresses 0..255 and data 8'hFF. The first grant is possible at edge 256.
- A writes 8'h5A to 8'h10, then reads 8'h10 → a_gnt each cycle. a_rvalid one cycle after the read, a_rdata = 8'h5A. b_rvalid stays 0.
- A and B read continuously (A addr 8'h01, B addr 8'h02) → grants alternate A, B, A, B with A first after reset. Each rvalid lands one cycle after its own grant.
- Same-edge hazard: B writes 8'h33 to 8'h20 at edge N, A reads 8'h20 at edge N+1 → a_rdata = 8'h33. Separately, a read accepted at the same edge as the write returns the prior value.
- init_start pulse while B holds a read request → B not granted until the refill completes 256 cycles later. Afterwards a read of an earlier-written address returns 8'hFF.
- reset_n pulsed low during cycle 100 of INIT → outputs return to reset values asynchronously. After release the fill restarts from address 0 and takes a full 256 cycles.
